apb_periph_bank: RTL and testbench
==================================

// Module: apb_periph_bank
// PURPOSE
//  APB completer stage fed by the bridge's APB outputs (PSEL[2:0], PENABLE, PWRITE, PADDR, PWDATA).
//  Holds three word-wide register banks, one per PSEL bit, and returns PRDATA to the bridge.
//  Checks APB phase sequencing, reports violations as a sticky flag plus a counter, and counts completed transfers.
// PARAMETERS
//  IDX_W   4   bank index width; each bank holds DEPTH = 2**IDX_W 32-bit words
//  CNT_W   16  width of the rd/wr/err counters
// PORTS
//  HCLK      in   1      single clock, all state updates on rising edge
//  HRESETn   in   1      synchronous active-low reset, sampled on HCLK rise
//  PSEL      in   3      one-hot slave select from bridge; bit n selects bank n
//  PENABLE   in   1      APB access-phase strobe
//  PWRITE    in   1      1 = write, 0 = read
//  PADDR     in   32     byte address; word index = PADDR[IDX_W+1:2]; other bits ignored
//  PWDATA    in   32     write data
//  clr_err   in   1      clears err_flag and err_cnt
//  PRDATA    out  32     registered read data returned to bridge
//  err_flag  out  1      sticky protocol-violation flag
//  err_cnt   out  CNT_W  protocol violations, saturating
//  wr_cnt    out  CNT_W  completed writes, saturating
//  rd_cnt    out  CNT_W  completed reads, saturating
// BEHAVIOUR
//  Reset: all bank words 0, PRDATA 0, err_flag 0, all counters 0, FSM = IDLE.
//  Valid setup cycle: PSEL has exactly one bit set, PENABLE = 0.
//  FSM (state reflects what the next cycle must be):
//   IDLE:
//    - valid setup -> ACCESS. Capture sel, idx, PWRITE, PWDATA.
//      If read: PRDATA <= bank[sel][idx] at the same edge, so it is valid throughout the access cycle.
//    - PSEL == 0 -> stay IDLE.
//    - PSEL != 0 with PENABLE = 1 (no preceding setup) -> violation, stay IDLE.
//    - PSEL with more than one bit set -> violation, stay IDLE.
//   ACCESS:
//    - PENABLE = 1 and PSEL/idx/PWRITE match the captured values -> transfer completes at this edge.
//      Write: bank[sel][idx] <= PWDATA, wr_cnt++. Read: rd_cnt++. Next state IDLE.
//    - PENABLE = 1 with any mismatch (PSEL/idx/PWRITE; PWDATA also for writes) -> violation, no write, no count, -> IDLE.
//    - PENABLE = 0 and valid setup -> violation (access abandoned); treated as a new setup, stay ACCESS, recapture.
//    - PENABLE = 0 and PSEL == 0 or PSEL not one-hot -> violation -> IDLE.
//  Back-to-back: setup may immediately follow access. Write-then-read to the same word returns the new data;
//    the write lands at the end of the access cycle, before the read is captured. No bypass logic.
//  PRDATA changes only on a read setup capture; otherwise it holds (writes never alter it).
//  Violation: err_flag <= 1, err_cnt++ (saturating at all-ones).
//  clr_err = 1: err_flag <= 0, err_cnt <= 0. If a violation occurs in the same cycle, the violation wins:
//    err_flag = 1, err_cnt = 1.
//  Counters saturate at 2**CNT_W-1 and never wrap.
//  Reset asserted mid-transfer: the transfer is dropped and no write occurs; all state returns to reset values next edge.
// TESTING
//  1. Reset; write PSEL=001, PADDR=0x8, PWDATA=0xDEADBEEF (setup+access), then read the same word
//     -> PRDATA = 0xDEADBEEF in the read access cycle; wr_cnt = 1, rd_cnt = 1, err_flag = 0.
//  2. Back-to-back: write bank2 idx 3 = 0x1234 immediately followed by a read of bank2 idx 3, no idle cycle
//     -> PRDATA = 0x1234; banks 0/1 idx 3 still read 0.
//  3. PENABLE = 1 with PSEL = 010 and no prior setup -> err_flag = 1, err_cnt = 1, no bank change, wr_cnt unchanged.
//  4. PADDR changes 0x4 -> 0x8 between setup and access of a write -> err_cnt++, neither word written, FSM back in IDLE.
//  5. PSEL = 011 -> violation, no access; then clr_err pulsed with no violation that cycle -> err_flag = 0, err_cnt = 0;
//     then clr_err in the same cycle as a new violation -> err_flag = 1, err_cnt = 1.
//  6. HRESETn low during the access cycle of a write to bank0 idx 1 = 0xAA -> the word stays 0 and all outputs are 0
//     after the edge. Separately, with CNT_W = 2, 5 writes -> wr_cnt = 3 (saturated).

Source files
------------

// File: rtl/apb_periph_bank.sv
// APB completer with three word-wide register banks selected by PSEL bits.
// Checks setup/access sequencing and counts violations and completed transfers.
module apb_periph_bank #(
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [2:0]       PSEL,
  input  logic             PENABLE,
  input  logic             PWRITE,
  input  logic [31:0]      PADDR,
  input  logic [31:0]      PWDATA,
  input  logic             clr_err,
  output logic [31:0]      PRDATA,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt
);

  localparam int DEPTH = 2 ** IDX_W;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state;
  logic [2:0]       cap_sel;
  logic [IDX_W-1:0] cap_idx;
  logic             cap_write;
  logic [31:0]      cap_wdata;
  logic [31:0]      bank [0:2][0:DEPTH-1];

  logic [IDX_W-1:0] idx;
  logic             one_hot;
  logic             valid_setup;
  logic             same_xfer;
  logic             viol;
  logic             do_capture;
  logic             do_write;
  logic             do_read;
  logic             unused_addr_bits;

  function automatic logic [1:0] sel_num(input logic [2:0] s);
    return s[2] ? 2'd2 : (s[1] ? 2'd1 : 2'd0);
  endfunction

  assign idx              = PADDR[IDX_W+1:2];
  assign unused_addr_bits = ^{PADDR[31:IDX_W+2], PADDR[1:0]};
  assign one_hot          = (PSEL != 3'b000) && ((PSEL & (PSEL - 3'd1)) == 3'b000);
  assign valid_setup      = one_hot && !PENABLE;
  assign same_xfer        = (PSEL == cap_sel) && (idx == cap_idx) && (PWRITE == cap_write) &&
                            (!cap_write || (PWDATA == cap_wdata));

  always_comb begin
    viol       = 1'b0;
    do_capture = 1'b0;
    do_write   = 1'b0;
    do_read    = 1'b0;
    case (state)
      IDLE: begin
        if (valid_setup)
          do_capture = 1'b1;
        else if (PSEL != 3'b000)
          viol = 1'b1;
      end
      ACCESS: begin
        if (PENABLE) begin
          if (same_xfer) begin
            do_write = cap_write;
            do_read  = !cap_write;
          end else begin
            viol = 1'b1;
          end
        end else begin
          // An abandoned access is still an error, but a fresh setup is honoured.
          viol       = 1'b1;
          do_capture = valid_setup;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state     <= IDLE;
      cap_sel   <= '0;
      cap_idx   <= '0;
      cap_write <= 1'b0;
      cap_wdata <= '0;
      PRDATA    <= '0;
      err_flag  <= 1'b0;
      err_cnt   <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      for (int b = 0; b < 3; b++)
        for (int w = 0; w < DEPTH; w++)
          bank[b][w] <= '0;
    end else begin
      state <= do_capture ? ACCESS : IDLE;

      if (do_capture) begin
        cap_sel   <= PSEL;
        cap_idx   <= idx;
        cap_write <= PWRITE;
        cap_wdata <= PWDATA;
        if (!PWRITE)
          PRDATA <= bank[sel_num(PSEL)][idx];
      end

      if (do_write) begin
        bank[sel_num(cap_sel)][cap_idx] <= cap_wdata;
        if (wr_cnt != '1)
          wr_cnt <= wr_cnt + 1'b1;
      end

      if (do_read && (rd_cnt != '1))
        rd_cnt <= rd_cnt + 1'b1;

      // A violation in the same cycle as clr_err restarts the count at one.
      if (viol) begin
        err_flag <= 1'b1;
        if (clr_err)
          err_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
        else if (err_cnt != '1)
          err_cnt <= err_cnt + 1'b1;
      end else if (clr_err) begin
        err_flag <= 1'b0;
        err_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_periph_bank.sv
// Directed bench for apb_periph_bank: transfers, protocol violations, error clear,
// mid-transfer reset and counter saturation (second instance with CNT_W = 2).
module tb_apb_periph_bank;

  logic        HCLK;
  logic        HRESETn;
  logic [2:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        clr_err;
  logic [31:0] PRDATA;
  logic        err_flag;
  logic [15:0] err_cnt;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;
  logic [31:0] sat_prdata;
  logic        sat_err_flag;
  logic [1:0]  sat_err_cnt;
  logic [1:0]  sat_wr_cnt;
  logic [1:0]  sat_rd_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] rdata;

  apb_periph_bank #(.IDX_W(4), .CNT_W(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .clr_err(clr_err), .PRDATA(PRDATA),
    .err_flag(err_flag), .err_cnt(err_cnt), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  apb_periph_bank #(.IDX_W(4), .CNT_W(2)) dut_sat (
    .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .clr_err(clr_err), .PRDATA(sat_prdata),
    .err_flag(sat_err_flag), .err_cnt(sat_err_cnt), .wr_cnt(sat_wr_cnt), .rd_cnt(sat_rd_cnt)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete setup + access transfer; rdata is PRDATA during the access cycle.
  task automatic applyStimulus(input logic [2:0] sel, input logic [31:0] addr, input logic wr,
                               input logic [31:0] wdata, output logic [31:0] rd);
    PSEL = sel; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge HCLK); #1;
    rd = PRDATA;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    PSEL = 3'b000; PENABLE = 1'b0;
  endtask

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  initial begin
    HRESETn = 1'b0; PSEL = 3'b000; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; clr_err = 1'b0;
    tick(); tick();
    HRESETn = 1'b1;
    checkOutput("reset_prdata", PRDATA, 32'h0);
    checkOutput("reset_err_flag", {31'b0, err_flag}, 32'h0);
    checkOutput("reset_err_cnt", {16'b0, err_cnt}, 32'h0);
    checkOutput("reset_wr_cnt", {16'b0, wr_cnt}, 32'h0);
    checkOutput("reset_rd_cnt", {16'b0, rd_cnt}, 32'h0);

    // Write then read bank0 word 2
    applyStimulus(3'b001, 32'h8, 1'b1, 32'hDEADBEEF, rdata);
    tick();
    applyStimulus(3'b001, 32'h8, 1'b0, 32'h0, rdata);
    checkOutput("t1_read", rdata, 32'hDEADBEEF);
    checkOutput("t1_wr_cnt", {16'b0, wr_cnt}, 32'd1);
    checkOutput("t1_rd_cnt", {16'b0, rd_cnt}, 32'd1);
    checkOutput("t1_err_flag", {31'b0, err_flag}, 32'h0);

    // Back-to-back write/read on bank2 word 3
    applyStimulus(3'b100, 32'hC, 1'b1, 32'h1234, rdata);
    checkOutput("t2_prdata_hold", PRDATA, 32'hDEADBEEF);
    applyStimulus(3'b100, 32'hC, 1'b0, 32'h0, rdata);
    checkOutput("t2_b2b_read", rdata, 32'h1234);
    applyStimulus(3'b001, 32'hC, 1'b0, 32'h0, rdata);
    checkOutput("t2_bank0_idx3", rdata, 32'h0);
    applyStimulus(3'b010, 32'hC, 1'b0, 32'h0, rdata);
    checkOutput("t2_bank1_idx3", rdata, 32'h0);
    checkOutput("t2_wr_cnt", {16'b0, wr_cnt}, 32'd2);
    checkOutput("t2_rd_cnt", {16'b0, rd_cnt}, 32'd4);
    checkOutput("t2_err_cnt", {16'b0, err_cnt}, 32'd0);

    // Access strobe with no prior setup
    PSEL = 3'b010; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'h55;
    tick();
    PSEL = 3'b000; PENABLE = 1'b0;
    checkOutput("t3_err_flag", {31'b0, err_flag}, 32'h1);
    checkOutput("t3_err_cnt", {16'b0, err_cnt}, 32'd1);
    checkOutput("t3_wr_cnt", {16'b0, wr_cnt}, 32'd2);
    tick();
    applyStimulus(3'b010, 32'h0, 1'b0, 32'h0, rdata);
    checkOutput("t3_bank1_idx0", rdata, 32'h0);

    // Address changes between setup and access
    PSEL = 3'b001; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'h77;
    tick();
    PENABLE = 1'b1; PADDR = 32'h8;
    tick();
    PSEL = 3'b000; PENABLE = 1'b0;
    checkOutput("t4_err_cnt", {16'b0, err_cnt}, 32'd2);
    checkOutput("t4_wr_cnt", {16'b0, wr_cnt}, 32'd2);
    applyStimulus(3'b001, 32'h4, 1'b0, 32'h0, rdata);
    checkOutput("t4_idx1_unwritten", rdata, 32'h0);
    applyStimulus(3'b001, 32'h8, 1'b0, 32'h0, rdata);
    checkOutput("t4_idx2_kept", rdata, 32'hDEADBEEF);
    checkOutput("t4_idle_after", {16'b0, err_cnt}, 32'd2);
    checkOutput("t4_rd_cnt", {16'b0, rd_cnt}, 32'd7);

    // Multi-bit select, then error clear with and without a concurrent violation
    PSEL = 3'b011; PENABLE = 1'b0; PWRITE = 1'b0;
    tick();
    PSEL = 3'b000;
    checkOutput("t5_multi_sel_cnt", {16'b0, err_cnt}, 32'd3);
    checkOutput("t5_rd_cnt", {16'b0, rd_cnt}, 32'd7);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checkOutput("t5_clr_flag", {31'b0, err_flag}, 32'h0);
    checkOutput("t5_clr_cnt", {16'b0, err_cnt}, 32'd0);
    clr_err = 1'b1; PSEL = 3'b011;
    tick();
    clr_err = 1'b0; PSEL = 3'b000;
    checkOutput("t5_clr_viol_flag", {31'b0, err_flag}, 32'h1);
    checkOutput("t5_clr_viol_cnt", {16'b0, err_cnt}, 32'd1);

    // Reset during the access cycle of a write
    PSEL = 3'b001; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h4; PWDATA = 32'hAA;
    tick();
    PENABLE = 1'b1; HRESETn = 1'b0;
    tick();
    checkOutput("t6_rst_prdata", PRDATA, 32'h0);
    checkOutput("t6_rst_err_flag", {31'b0, err_flag}, 32'h0);
    checkOutput("t6_rst_err_cnt", {16'b0, err_cnt}, 32'h0);
    checkOutput("t6_rst_wr_cnt", {16'b0, wr_cnt}, 32'h0);
    checkOutput("t6_rst_rd_cnt", {16'b0, rd_cnt}, 32'h0);
    PSEL = 3'b000; PENABLE = 1'b0; HRESETn = 1'b1;
    tick();
    applyStimulus(3'b001, 32'h4, 1'b0, 32'h0, rdata);
    checkOutput("t6_word_dropped", rdata, 32'h0);

    // Saturation: five writes after a fresh reset
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    for (int k = 0; k < 5; k++)
      applyStimulus(3'b010, 32'(k * 4), 1'b1, 32'h100 + 32'(k), rdata);
    checkOutput("t6_wr_cnt_16", {16'b0, wr_cnt}, 32'd5);
    checkOutput("t6_wr_cnt_sat", {30'b0, sat_wr_cnt}, 32'd3);
    applyStimulus(3'b010, 32'h10, 1'b0, 32'h0, rdata);
    checkOutput("t6_last_write", rdata, 32'h104);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
